// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared FSM states, segment codes and BCD helpers for the hex display
package hex_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam int CONV_BITS = 7;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: active-low seven-segment decode of one BCD digit, codes 10-15 show a dash
module bcd_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  assign seg = bcd < 4'd10 ? SEG_DIGIT[bcd] : SEG_DASH;
endmodule

// File: rtl/out_port_hex_display.sv
// out_port_hex_display: double-dabble three CPU output ports onto six digits; HEX_LEADING_ZERO_BLANK_EN blanks a zero tens digit
module out_port_hex_display
  import hex_display_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        update
);
  state_t state, state_next;
  logic [31:0] port [3];
  logic [31:0] snap [3];
  logic [CONV_BITS-1:0] sh [3];
  logic [8:0] acc [3];
  logic [8:0] acc_next [3];
  logic [6:0] seg [6];
  logic [6:0] disp [6];
  logic [6:0] hex_q [6];
  logic [2:0] count;
  logic pending;
  logic changed;
  assign port[0] = out_port0;
  assign port[1] = out_port1;
  assign port[2] = out_port2;
  assign changed = (port[0] != snap[0]) || (port[1] != snap[1]) || (port[2] != snap[2]);
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic ovf;
    bcd_to_seg7 u_ones (.bcd(acc[c][3:0]), .seg(seg[2*c]));
    bcd_to_seg7 u_tens (.bcd(acc[c][7:4]), .seg(seg[2*c+1]));
    // bit 8 is the hundreds position; it can only be reached on the last shift, so nothing is lost
    assign acc_next[c] = {add3(acc[c][7:4]), add3(acc[c][3:0]), sh[c][CONV_BITS-1]};
    assign ovf = (|snap[c][31:CONV_BITS]) || acc[c][8] || (acc[c][7:4] >= 4'd10);
    assign disp[2*c] = ovf ? SEG_DASH : seg[2*c];
`ifdef HEX_LEADING_ZERO_BLANK_EN
    assign disp[2*c+1] = ovf ? SEG_DASH : (acc[c][7:4] == 4'd0) ? SEG_BLANK : seg[2*c+1];
`else
    assign disp[2*c+1] = ovf ? SEG_DASH : seg[2*c+1];
`endif
  end
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (changed || pending) ? SHIFT : IDLE;
      SHIFT:   state_next = (count == 3'd1) ? COMMIT : SHIFT;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b1;
      busy <= 1'b0;
      update <= 1'b0;
      count <= '0;
      for (int i = 0; i < 3; i++) begin
        snap[i] <= '0;
        sh[i] <= '0;
        acc[i] <= '0;
      end
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      update <= 1'b0;
      if (state == IDLE && state_next == SHIFT) begin
        for (int i = 0; i < 3; i++) begin
          snap[i] <= port[i];
          sh[i] <= port[i][CONV_BITS-1:0];
          acc[i] <= '0;
        end
        count <= 3'(CONV_BITS);
        pending <= 1'b0;
        busy <= 1'b1;
      end else if (state == SHIFT) begin
        for (int i = 0; i < 3; i++) begin
          acc[i] <= acc_next[i];
          sh[i] <= sh[i] << 1;
        end
        count <= count - 3'd1;
      end else if (state == COMMIT) begin
        for (int i = 0; i < 6; i++) hex_q[i] <= disp[i];
        update <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
endmodule

// File: tb/tb_out_port_hex_display.sv
// tb_out_port_hex_display: random and directed port changes scored against a decimal reference model
module tb_out_port_hex_display;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] out_port0 = '0, out_port1 = '0, out_port2 = '0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic busy, update;
  out_port_hex_display dut (
    .clock(clock), .reset(reset),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .update(update)
  );
  always #5 clock = ~clock;
  localparam logic [6:0] DIGIT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_timer = 0;
  logic m_pending = 1'b1;
  logic m_busy = 1'b0;
  logic m_upd = 1'b0;
  logic [31:0] m_snap [3] = '{0, 0, 0};
  logic [41:0] m_disp = {6{7'h7F}};
  int q_due [$];
  logic [41:0] q_hex [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // expected {tens, ones} segments for one channel, from plain decimal arithmetic
  function automatic logic [13:0] ch_exp(input logic [31:0] v);
    logic [6:0] t, o;
    if (v > 32'd99) return {7'h3F, 7'h3F};
    t = DIGIT[v / 10];
    o = DIGIT[v % 10];
`ifdef HEX_LEADING_ZERO_BLANK_EN
    if (v < 32'd10) t = 7'h7F;
`endif
    return {t, o};
  endfunction
  always @(posedge clock) begin
    cyc++;
    m_upd = 1'b0;
    if (reset) begin
      if (m_timer > 0) begin
        void'(q_due.pop_back());
        void'(q_hex.pop_back());
      end
      m_timer = 0;
      m_pending = 1'b1;
      m_busy = 1'b0;
      m_snap = '{0, 0, 0};
      m_disp = {6{7'h7F}};
    end else if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) begin
        m_busy = 1'b0;
        m_upd = 1'b1;
      end
    end else if (m_pending || out_port0 != m_snap[0] || out_port1 != m_snap[1] || out_port2 != m_snap[2]) begin
      m_snap = '{out_port0, out_port1, out_port2};
      m_pending = 1'b0;
      m_busy = 1'b1;
      m_timer = 8;
      q_due.push_back(cyc + 8);
      q_hex.push_back({ch_exp(out_port2), ch_exp(out_port1), ch_exp(out_port0)});
    end
  end
  always @(negedge clock) begin
    if (cyc > 0) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("update", 64'(update), 64'(m_upd));
      if (update) begin
        if (q_due.size() == 0) begin
          chk("unexpected_update", 64'(update), 64'd0);
        end else begin
          chk("update_cycle", 64'(cyc), 64'(q_due.pop_front()));
          m_disp = q_hex.pop_front();
        end
      end
      chk("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(m_disp));
    end
  end
  task automatic settle();
    int n = 0;
    while (!(m_timer == 0 && !m_pending && out_port0 == m_snap[0] && out_port1 == m_snap[1]
             && out_port2 == m_snap[2]) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("settle_timeout", 64'(n), 64'd0);
    @(negedge clock);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("reset_blank", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), {22'd0, {6{7'h7F}}});
    reset = 1'b0;
    settle();
    out_port2 = 32'd57;
    settle();
    chk("ch2_57", 64'({hex5, hex4}), 64'({7'h12, 7'h78}));
    out_port0 = 32'd100;
    settle();
    chk("ch0_100", 64'({hex1, hex0}), 64'({7'h3F, 7'h3F}));
    out_port1 = 32'hFFFF_FF85;
    settle();
    chk("ch1_neg", 64'({hex3, hex2}), 64'({7'h3F, 7'h3F}));
    out_port1 = 32'd42;
    repeat (2) @(negedge clock);
    out_port1 = 32'd9;
    settle();
    chk("ch1_9_ones", 64'(hex2), 64'h10);
    out_port0 = 32'd33;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    settle();
    chk("after_reset_ch0", 64'({hex1, hex0}), 64'({7'h30, 7'h30}));
    out_port0 = 32'd99;
    settle();
    chk("ch0_99", 64'({hex1, hex0}), 64'({7'h10, 7'h10}));
    for (int k = 0; k < 80; k++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      case ($urandom_range(0, 2))
        0: out_port0 = v;
        1: out_port1 = v;
        default: out_port2 = v;
      endcase
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 12)) @(negedge clock);
    end
    settle();
    chk("queue_empty", 64'(q_due.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
